hazard_fwd_unit: RTL

- Consumer end of the instruction-decoder interface. Takes the decoder's ID-stage outputs (rs1use, rs2use, hazard_optype) plus register indices.
- Internally tracks the destination and type of the instructions in EX and MEM. From that it produces forwarding selects, a load-use stall, and a branch flush for the 5-stage pipeline.
- Branch compare and operand muxing happen in ID, so forwarding targets the ID operand muxes.

---
 rtl/hazard_fwd_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage RISC-V pipeline.
// Tracks EX/MEM destinations and steers the ID operand muxes.
module hazard_fwd_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rs1use_id,
  input  logic             rs2use_id,
  input  logic [1:0]       hazard_optype_id,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             Branch_id,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } optype_e;

  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EX_ALU = 2'b01;
  localparam logic [1:0] SEL_MEM_AL = 2'b10;
  localparam logic [1:0] SEL_MEM_LD = 2'b11;

  localparam logic [REG_W-1:0] X0 = '0;

  logic [1:0]       optype_exe_q, optype_exe_d;
  logic [1:0]       optype_mem_q, optype_mem_d;
  logic [REG_W-1:0] rd_exe_q, rd_exe_d;
  logic [REG_W-1:0] rd_mem_q, rd_mem_d;
  logic [REG_W-1:0] rs2_exe_q, rs2_exe_d;

  logic wr_exe, wr_mem;
  logic ld_exe, ld_mem;
  logic hit_ex_a, hit_ex_b;
  logic hit_mem_a, hit_mem_b;
  logic ld_hit_a, ld_hit_b;
  logic id_store;
  logic stall;

  assign wr_exe = (optype_exe_q == OP_ALU)
               || (optype_exe_q == OP_LOAD);
  assign wr_mem = (optype_mem_q == OP_ALU)
               || (optype_mem_q == OP_LOAD);
  assign ld_exe = (optype_exe_q == OP_LOAD);
  assign ld_mem = (optype_mem_q == OP_LOAD);

  assign hit_ex_a = rs1use_id
                 && (rs1_id == rd_exe_q)
                 && (rd_exe_q != X0)
                 && wr_exe;
  assign hit_ex_b = rs2use_id
                 && (rs2_id == rd_exe_q)
                 && (rd_exe_q != X0)
                 && wr_exe;
  assign hit_mem_a = rs1use_id
                  && (rs1_id == rd_mem_q)
                  && (rd_mem_q != X0)
                  && wr_mem;
  assign hit_mem_b = rs2use_id
                  && (rs2_id == rd_mem_q)
                  && (rd_mem_q != X0)
                  && wr_mem;

  assign ld_hit_a = hit_ex_a && ld_exe;
  assign ld_hit_b = hit_ex_b && ld_exe;
  assign id_store = (hazard_optype_id == OP_STORE);

  // A store's data operand can wait a cycle for forward_ctrl_ls.
  assign stall = ld_hit_a || (ld_hit_b && !id_store);

  always_comb begin
    forward_ctrl_A = SEL_RF;
    unique case (1'b1)
      hit_ex_a:
        forward_ctrl_A = ld_exe ? SEL_RF : SEL_EX_ALU;
      (!hit_ex_a && hit_mem_a):
        forward_ctrl_A = ld_mem ? SEL_MEM_LD : SEL_MEM_AL;
      default:
        forward_ctrl_A = SEL_RF;
    endcase
  end

  always_comb begin
    forward_ctrl_B = SEL_RF;
    unique case (1'b1)
      hit_ex_b:
        forward_ctrl_B = ld_exe ? SEL_RF : SEL_EX_ALU;
      (!hit_ex_b && hit_mem_b):
        forward_ctrl_B = ld_mem ? SEL_MEM_LD : SEL_MEM_AL;
      default:
        forward_ctrl_B = SEL_RF;
    endcase
  end

  assign forward_ctrl_ls = (optype_exe_q == OP_STORE)
                        && ld_mem
                        && (rs2_exe_q == rd_mem_q)
                        && (rd_mem_q != X0);

  assign PC_EN_IF     = !stall;
  assign reg_FD_EN    = !stall;
  assign reg_DE_flush = stall;
  assign reg_FD_flush = Branch_id && !stall;

  always_comb begin
    optype_mem_d = optype_exe_q;
    rd_mem_d     = rd_exe_q;
    optype_exe_d = hazard_optype_id;
    rd_exe_d     = rd_id;
    rs2_exe_d    = rs2_id;
    if (stall) begin
      optype_exe_d = OP_NONE;
      rd_exe_d     = '0;
      rs2_exe_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      optype_exe_q <= OP_NONE;
      optype_mem_q <= OP_NONE;
      rd_exe_q     <= '0;
      rd_mem_q     <= '0;
      rs2_exe_q    <= '0;
    end else begin
      optype_exe_q <= optype_exe_d;
      optype_mem_q <= optype_mem_d;
      rd_exe_q     <= rd_exe_d;
      rd_mem_q     <= rd_mem_d;
      rs2_exe_q    <= rs2_exe_d;
    end
  end

endmodule
